serial_add_ctrl: RTL and testbench

Bit-serial sequencer that drives the gate-level 1-bit adder cell (addbit) one bit per clock, LSB first. It feeds the cell's carry-out back as the next carry-in and collects the sum bits into a WIDTH-bit result. It sits directly upstream of the adder cell and also consumes that cell's outputs. It is the team's vehicle for exercising specify-block delays under clocked operation.

---
 rtl/serial_add_pkg.sv | 20 ++
 rtl/serial_shreg.sv | 41 ++++
 rtl/serial_add_ctrl.sv | 149 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_add_pkg;

  // Sequencer states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Default operand / result width.
  localparam int DEF_WIDTH = 8;

  // Shortest clk period (ns) that still lets the adder cell's worst-case
  // path (5 ns) settle between two edges.
  localparam int CLK_PERIOD_FLOOR_NS = 10;

endpackage

// File: rtl/serial_shreg.sv
// Parallel-load right-shift register; presents its LSB as the serial output.
// Latency: load/shift take effect at the next rising clk edge.
// Backpressure: none; load has priority over shift, zero fill on shift.
//
// Ports: clk, rst (async, active high), load, shift, din[WIDTH-1:0], dout (= bit 0).
module serial_shreg
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift) begin
      data_d = {1'b0, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign dout = data_q[0];

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer driving an external 1-bit adder cell, LSB first.
// Latency: start accepted at edge k -> done pulses in the cycle after edge k+WIDTH.
// Backpressure: none; start is only sampled in IDLE, otherwise dropped (never queued).
//
// Ports: clk, rst (async, active high), start, op_a/op_b (captured on accept),
//        add_a/add_b/add_ci -> adder cell, add_sum/add_co <- adder cell,
//        busy, done (1-cycle pulse), result, carry_out (held until next op).
// Optional: define SERIAL_ADD_SUB_EN to add a `sub` input (result = op_a - op_b,
//           carry_out = 1 means no borrow).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             add_a,
  output logic             add_b,
  output logic             add_ci,
  input  logic             add_sum,
  input  logic             add_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             load;
  logic             shift_en;
  logic             sa_lsb;
  logic             sb_lsb;
  logic             sub_in;
  logic [WIDTH-1:0] b_load;

  // Subtraction is a + ~b + 1: invert B on load and seed the carry with 1.
`ifdef SERIAL_ADD_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif
  assign b_load = op_b ^ {WIDTH{sub_in}};

  serial_shreg #(.WIDTH(WIDTH)) u_shreg_a (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift_en),
    .din   (op_a),
    .dout  (sa_lsb)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_shreg_b (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift_en),
    .din   (b_load),
    .dout  (sb_lsb)
  );

  always_comb begin
    state_d     = state_q;
    cy_d        = cy_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    done_d      = 1'b0;
    load        = 1'b0;
    shift_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cy_d    = sub_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The adder cell has settled on this bit by now; bank it and advance.
        shift_en = 1'b1;
        result_d = {add_sum, result_q[WIDTH-1:1]};
        cy_d     = add_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          carry_out_d = add_co;
          done_d      = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cy_q        <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cy_q        <= cy_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Adder inputs come straight from flops so the cell sees a full clk period.
  assign add_a     = sa_lsb;
  assign add_b     = sb_lsb;
  assign add_ci    = cy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a behavioural 1-bit adder cell.
// Latency: done expected WIDTH edges after the accepting edge.
// Backpressure: start is held / pulsed to probe IDLE-only acceptance.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         add_a, add_b, add_ci;
  logic         add_sum, add_co;
  logic         busy, done;
  logic [W-1:0] result;
  logic         carry_out;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  logic [W-1:0] tab_a[5];
  logic [W-1:0] tab_b[5];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .op_a      (op_a),
    .op_b      (op_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_sum   (add_sum),
    .add_co    (add_co),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  // Behavioural full-adder cell.
  assign add_sum = add_a ^ add_b ^ add_ci;
  assign add_co  = (add_a & add_b) | (add_a & add_ci) | (add_b & add_ci);

  initial clk = 1'b0;
  always #(CLK_PERIOD_FLOOR_NS / 2) clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive operands with start for one edge; optionally queue the expected result.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input bit push);
    logic [W:0] full;
    exp_t       e;
    op_a  = a;
    op_b  = b;
`ifdef SERIAL_ADD_SUB_EN
    sub   = s;
`endif
    start = 1'b1;
    if (s) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   full = {1'b0, a} + {1'b0, b};
    e.r = full[W-1:0];
    e.c = full[W];
    if (push) sb_q.push_back(e);
    tick;
    start = 1'b0;
  endtask

  // Bounded wait for done; lat = edges after the accepting edge, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= W + 4; i++) begin
      tick;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== '0)      begin errors++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
    checks++; if ({add_a, add_b, add_ci} !== 3'b000) begin
      errors++; $display("FAIL reset_adder_in got=%b exp=000", {add_a, add_b, add_ci});
    end
    rst = 1'b0;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_add;
    int   lat;
    exp_t e;
    for (int t = 0; t < 5; t++) begin
      launch(tab_a[t], tab_b[t], 1'b0, 1'b1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy[%0d] got=%b exp=1", t, busy); end
      wait_done(lat);
      e = sb_q.pop_front();
      checks++; if (lat !== W) begin errors++; $display("FAIL add_latency[%0d] got=%0d exp=%0d", t, lat, W); end
      checks++; if (result !== e.r) begin errors++; $display("FAIL add_result[%0d] got=%h exp=%h", t, result, e.r); end
      checks++; if (carry_out !== e.c) begin errors++; $display("FAIL add_carry[%0d] got=%b exp=%b", t, carry_out, e.c); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_done[%0d] got=%b exp=0", t, busy); end
      tick;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_width[%0d] got=%b exp=0", t, done); end
      tick;
      tick;
      checks++; if (result !== e.r) begin errors++; $display("FAIL add_hold[%0d] got=%h exp=%h", t, result, e.r); end
    end
  endtask

  task automatic test_carry_chain;
    exp_t e;
    launch(8'hFF, 8'h01, 1'b0, 1'b1);
    for (int i = 1; i <= W - 1; i++) begin
      tick;
      checks++; if (add_ci !== 1'b1) begin errors++; $display("FAIL carry_ci[%0d] got=%b exp=1", i, add_ci); end
    end
    tick;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL carry_done got=%b exp=1", done); end
    e = sb_q.pop_front();
    checks++; if (result !== e.r) begin errors++; $display("FAIL carry_result got=%h exp=%h", result, e.r); end
    checks++; if (carry_out !== e.c) begin errors++; $display("FAIL carry_flag got=%b exp=%b", carry_out, e.c); end
    tick;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   n_done = 0;
    logic prev_done = 1'b0;
    logic exp_busy;
    sb_q.push_back('{r: 8'h10, c: 1'b0});
    sb_q.push_back('{r: 8'h10, c: 1'b0});
    op_a  = 8'h0F;
    op_b  = 8'h01;
    start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick;
      exp_busy = ((c % 10) < 8);
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", c, busy, exp_busy); end
      if (done === 1'b1) begin
        n_done++;
        checks++; if (prev_done !== 1'b0) begin errors++; $display("FAIL b2b_done_width[%0d] got=1 exp=0", c); end
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checks++; if (result !== e.r) begin errors++; $display("FAIL b2b_result[%0d] got=%h exp=%h", c, result, e.r); end
          checks++; if (carry_out !== e.c) begin errors++; $display("FAIL b2b_carry[%0d] got=%b exp=%b", c, carry_out, e.c); end
        end
      end
      prev_done = done;
    end
    start = 1'b0;
    checks++; if (n_done !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", n_done); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL b2b_queue got=%0d exp=0", sb_q.size()); end
    tick;
    tick;
  endtask

  task automatic test_reset_mid_shift;
    int   lat;
    exp_t e;
    logic saw_done = 1'b0;
    launch(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (4) tick;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got=%b exp=1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (result !== '0)  begin errors++; $display("FAIL abort_result got=%h exp=00", result); end
    checks++; if (add_ci !== 1'b0) begin errors++; $display("FAIL abort_ci got=%b exp=0", add_ci); end
    #1 rst = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      tick;
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
    launch(8'h01, 8'h01, 1'b0, 1'b1);
    wait_done(lat);
    e = sb_q.pop_front();
    checks++; if (lat !== W) begin errors++; $display("FAIL abort_next_latency got=%0d exp=%0d", lat, W); end
    checks++; if (result !== e.r) begin errors++; $display("FAIL abort_next_result got=%h exp=%h", result, e.r); end
    tick;
  endtask

  task automatic test_operand_change;
    exp_t e;
    logic got = 1'b0;
    launch(8'h12, 8'h34, 1'b0, 1'b1);
    for (int i = 0; i < W + 4; i++) begin
      op_a = W'($urandom);
      op_b = W'($urandom);
      tick;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    e = sb_q.pop_front();
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL opchg_done got=%b exp=1", got); end
    checks++; if (result !== e.r) begin errors++; $display("FAIL opchg_result got=%h exp=%h", result, e.r); end
    tick;
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    int   lat;
    exp_t e;
    launch(8'h10, 8'h01, 1'b1, 1'b1);
    wait_done(lat);
    e = sb_q.pop_front();
    checks++; if (result !== e.r) begin errors++; $display("FAIL sub0_result got=%h exp=%h", result, e.r); end
    checks++; if (carry_out !== e.c) begin errors++; $display("FAIL sub0_carry got=%b exp=%b", carry_out, e.c); end
    tick;
    launch(8'h01, 8'h02, 1'b1, 1'b1);
    wait_done(lat);
    e = sb_q.pop_front();
    checks++; if (result !== e.r) begin errors++; $display("FAIL sub1_result got=%h exp=%h", result, e.r); end
    checks++; if (carry_out !== e.c) begin errors++; $display("FAIL sub1_carry got=%b exp=%b", carry_out, e.c); end
    tick;
    sub = 1'b0;
  endtask
`endif

  initial begin
    tab_a[0] = 8'h35; tab_b[0] = 8'h4A;
    tab_a[1] = 8'h00; tab_b[1] = 8'h00;
    tab_a[2] = 8'h80; tab_b[2] = 8'h80;
    tab_a[3] = 8'hFF; tab_b[3] = 8'hFF;
    tab_a[4] = 8'hC3; tab_b[4] = 8'h3C;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    test_reset;
    test_add;
    test_carry_chain;
    test_back_to_back;
    test_reset_mid_shift;
    test_operand_change;
`ifdef SERIAL_ADD_SUB_EN
    test_sub;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
